// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares one single-port synchronous memory between the CPU and a debug/loader
// port. The CPU owns the bus by default; a debug request steals one CPU read
// cycle pair (ISSUE, DONE) by dropping cpu_rdy. A halt mode hands the bus to the
// debug port until it is released, with one RESUME cycle on the way out.
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   cpu_addr/wr_data/wr_enable      CPU request
//   cpu_rd_data, cpu_rdy            CPU read data (from memory), cycle complete
//   dbg_req/addr/wr_enable/wr_data  debug request, held until dbg_ack
//   dbg_ack, dbg_rd_data            completion pulse, read data (held)
//   dbg_halt, halted                halt request level, halted status
//   dbg_starve                      sticky: debug request blocked too long
//   mem_addr/wr_enable/wr_data      to memory addra/wea/dina
//   mem_rd_data                     from memory douta (one-cycle read latency)
module mem_bus_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 8,
  parameter int DBG_MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wr_data,
  input  logic              cpu_wr_enable,
  output logic [DATA_W-1:0] cpu_rd_data,
  output logic              cpu_rdy,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic              dbg_wr_enable,
  input  logic [DATA_W-1:0] dbg_wr_data,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rd_data,
  input  logic              dbg_halt,
  output logic              halted,
  output logic              dbg_starve,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr_enable,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data
);

  localparam int CNT_W = $clog2(DBG_MAX_WAIT + 1);

  typedef enum logic [2:0] {
    ST_CPU,
    ST_ISSUE,
    ST_DONE,
    ST_HALTED,
    ST_RESUME
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               dbg_we_p1;
  logic [DATA_W-1:0]  dbg_rd_hold;
  logic [CNT_W-1:0]   wait_cnt;
  logic               grant;

  // Only CPU read cycles may be stolen; halt takes priority over a request.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_CPU: begin
        if (!cpu_wr_enable) begin
          if (dbg_halt)     state_nxt = ST_HALTED;
          else if (dbg_req) state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE:  state_nxt = ST_DONE;
      ST_DONE:   state_nxt = dbg_halt ? ST_HALTED : ST_CPU;
      ST_HALTED: begin
        if (dbg_req)        state_nxt = ST_ISSUE;
        else if (!dbg_halt) state_nxt = ST_RESUME;
      end
      ST_RESUME: state_nxt = ST_CPU;
      default:   state_nxt = ST_CPU;
    endcase
  end

  assign grant = (state == ST_CPU) && (state_nxt == ST_ISSUE);

  // Status outputs are registered alongside the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_CPU;
      cpu_rdy <= 1'b1;
      dbg_ack <= 1'b0;
      halted  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cpu_rdy <= (state_nxt == ST_CPU);
      dbg_ack <= (state_nxt == ST_DONE);
      halted  <= (state_nxt == ST_HALTED);
    end
  end

  // Outside CPU and ISSUE the CPU address is re-presented with writes blocked,
  // so mem_rd_data is already correct in the first cycle cpu_rdy is back high.
  always_comb begin
    mem_addr      = cpu_addr;
    mem_wr_enable = 1'b0;
    mem_wr_data   = cpu_wr_data;
    case (state)
      ST_CPU: mem_wr_enable = cpu_wr_enable;
      ST_ISSUE: begin
        mem_addr      = dbg_addr;
        mem_wr_enable = dbg_wr_enable;
        mem_wr_data   = dbg_wr_data;
      end
      default: ;
    endcase
  end

  assign cpu_rd_data = mem_rd_data;

  // Stage p1: remember whether the access issued last cycle was a write.
  always_ff @(posedge clk) begin
    if (state == ST_ISSUE) dbg_we_p1 <= dbg_wr_enable;
  end

  // Read data is passed straight through in DONE and held afterwards;
  // a debug write leaves the previous read value in place.
  always_ff @(posedge clk) begin
    if (reset)                               dbg_rd_hold <= '0;
    else if (state == ST_DONE && !dbg_we_p1) dbg_rd_hold <= mem_rd_data;
  end

  assign dbg_rd_data = (state == ST_DONE && !dbg_we_p1) ? mem_rd_data : dbg_rd_hold;

  // Counts cycles a pending request is blocked by CPU writes; saturates.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt   <= '0;
      dbg_starve <= 1'b0;
    end else if (state == ST_CPU && dbg_req && cpu_wr_enable) begin
      if (wait_cnt < CNT_W'(DBG_MAX_WAIT)) wait_cnt <= wait_cnt + CNT_W'(1);
      if (wait_cnt >= CNT_W'(DBG_MAX_WAIT - 1)) dbg_starve <= 1'b1;
    end else if (!dbg_req || grant) begin
      wait_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a read-first synchronous memory model.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wr_data;
  logic        cpu_wr_enable;
  logic [7:0]  cpu_rd_data;
  logic        cpu_rdy;
  logic        dbg_req;
  logic [15:0] dbg_addr;
  logic        dbg_wr_enable;
  logic [7:0]  dbg_wr_data;
  logic        dbg_ack;
  logic [7:0]  dbg_rd_data;
  logic        dbg_halt;
  logic        halted;
  logic        dbg_starve;
  logic [15:0] mem_addr;
  logic        mem_wr_enable;
  logic [7:0]  mem_wr_data;
  logic [7:0]  mem_rd_data;

  logic [7:0]  mem [0:65535];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(16), .DATA_W(8), .DBG_MAX_WAIT(8)) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_wr_data(cpu_wr_data), .cpu_wr_enable(cpu_wr_enable),
    .cpu_rd_data(cpu_rd_data), .cpu_rdy(cpu_rdy),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_wr_enable(dbg_wr_enable),
    .dbg_wr_data(dbg_wr_data), .dbg_ack(dbg_ack), .dbg_rd_data(dbg_rd_data),
    .dbg_halt(dbg_halt), .halted(halted), .dbg_starve(dbg_starve),
    .mem_addr(mem_addr), .mem_wr_enable(mem_wr_enable), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data)
  );

  always @(posedge clk) begin
    if (mem_wr_enable) mem[mem_addr] <= mem_wr_data;
    mem_rd_data <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) begin
      logic [15:0] a;
      a = 16'(i);
      mem[i] = a[7:0] ^ a[15:8] ^ 8'h3C;
    end
    mem[16'h8000] = 8'hA9;
    mem_rd_data   = 8'h00;

    reset = 1'b1; cpu_addr = 16'h0000; cpu_wr_data = 8'h00; cpu_wr_enable = 1'b0;
    dbg_req = 1'b0; dbg_addr = 16'h0000; dbg_wr_enable = 1'b0; dbg_wr_data = 8'h00;
    dbg_halt = 1'b0;

    // T1: reset
    repeat (4) cyc();
    check("rst_cpu_rdy", cpu_rdy, 1);
    check("rst_ack", dbg_ack, 0);
    check("rst_rd_data", dbg_rd_data, 0);
    reset = 1'b0;
    cpu_addr = 16'h1234;
    #1;
    check("t1_mem_addr", mem_addr, 16'h1234);
    check("t1_halted", halted, 0);
    check("t1_starve", dbg_starve, 0);
    cyc();
    check("t1_cpu_rdy", cpu_rdy, 1);
    check("t1_ack", dbg_ack, 0);

    // T2: stolen debug read
    cpu_addr = 16'h0010;
    dbg_req = 1'b1; dbg_addr = 16'h8000; dbg_wr_enable = 1'b0;
    #1;
    check("t2_rdy_before", cpu_rdy, 1);
    cyc();
    check("t2_issue_rdy", cpu_rdy, 0);
    check("t2_issue_addr", mem_addr, 16'h8000);
    check("t2_issue_ack", dbg_ack, 0);
    cyc();
    check("t2_done_rdy", cpu_rdy, 0);
    check("t2_done_ack", dbg_ack, 1);
    check("t2_done_data", dbg_rd_data, 8'hA9);
    check("t2_done_addr", mem_addr, 16'h0010);
    dbg_req = 1'b0;
    cyc();
    check("t2_back_rdy", cpu_rdy, 1);
    check("t2_back_ack", dbg_ack, 0);
    check("t2_cpu_rd", cpu_rd_data, 8'h2C);
    check("t2_hold_data", dbg_rd_data, 8'hA9);

    // T3: CPU writes block the request
    cpu_addr = 16'h0300; cpu_wr_data = 8'h11; cpu_wr_enable = 1'b1;
    dbg_req = 1'b1; dbg_addr = 16'h8000; dbg_wr_enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t3_rdy_wr", cpu_rdy, 1);
      check("t3_mem_we", mem_wr_enable, 1);
      cyc();
    end
    cpu_wr_enable = 1'b0;
    #1;
    check("t3_rdy_rd", cpu_rdy, 1);
    cyc();
    check("t3_issue_rdy", cpu_rdy, 0);
    check("t3_issue_addr", mem_addr, 16'h8000);
    check("t3_starve", dbg_starve, 0);
    cyc();
    check("t3_done_ack", dbg_ack, 1);
    check("t3_done_data", dbg_rd_data, 8'hA9);
    dbg_req = 1'b0;
    cyc();
    check("t3_back_rdy", cpu_rdy, 1);
    check("t3_wr_mem", mem[16'h0300], 8'h11);

    // T4: halt, four writes, four reads, release
    dbg_halt = 1'b1;
    cyc();
    for (int i = 0; i < 4; i++) begin
      check("t4w_halted", halted, 1);
      check("t4w_rdy", cpu_rdy, 0);
      dbg_req = 1'b1; dbg_addr = 16'h0200 + 16'(i); dbg_wr_enable = 1'b1;
      dbg_wr_data = 8'hC0 + 8'(i);
      cyc();
      check("t4w_issue_we", mem_wr_enable, 1);
      check("t4w_issue_addr", mem_addr, 16'h0200 + 16'(i));
      check("t4w_issue_data", mem_wr_data, 8'hC0 + 8'(i));
      cyc();
      check("t4w_ack", dbg_ack, 1);
      check("t4w_rd_held", dbg_rd_data, 8'hA9);
      cyc();
    end
    for (int i = 0; i < 4; i++) begin
      check("t4r_halted", halted, 1);
      dbg_req = 1'b1; dbg_addr = 16'h0200 + 16'(i); dbg_wr_enable = 1'b0;
      cyc();
      check("t4r_issue_we", mem_wr_enable, 0);
      cyc();
      check("t4r_ack", dbg_ack, 1);
      check("t4r_data", dbg_rd_data, 8'hC0 + 8'(i));
      cyc();
    end
    check("t4_still_halted", halted, 1);
    dbg_req = 1'b0; dbg_halt = 1'b0;
    cyc();
    check("t4_resume_rdy", cpu_rdy, 0);
    check("t4_resume_halted", halted, 0);
    check("t4_resume_we", mem_wr_enable, 0);
    cyc();
    check("t4_cpu_rdy", cpu_rdy, 1);

    // T5: starvation
    cpu_addr = 16'h0400; cpu_wr_data = 8'h55; cpu_wr_enable = 1'b1;
    dbg_req = 1'b1; dbg_addr = 16'h8000; dbg_wr_enable = 1'b0;
    #1;
    for (int k = 0; k < 10; k++) begin
      check("t5_starve", dbg_starve, (k >= 8) ? 1 : 0);
      cyc();
    end
    cpu_wr_enable = 1'b0;
    cyc();
    check("t5_issue_rdy", cpu_rdy, 0);
    cyc();
    check("t5_ack", dbg_ack, 1);
    dbg_req = 1'b0;
    cyc();
    check("t5_sticky", dbg_starve, 1);
    cyc();
    check("t5_sticky2", dbg_starve, 1);
    reset = 1'b1;
    cyc();
    check("t5_rst_clear", dbg_starve, 0);
    reset = 1'b0;
    cyc();

    // T6: reset in ISSUE of a read, then of a write
    dbg_req = 1'b1; dbg_addr = 16'h8000; dbg_wr_enable = 1'b0;
    cyc();
    check("t6_issue_rdy", cpu_rdy, 0);
    reset = 1'b1;
    cyc();
    check("t6_rst_rdy", cpu_rdy, 1);
    check("t6_rst_ack", dbg_ack, 0);
    reset = 1'b0; dbg_req = 1'b0;
    cyc();
    check("t6_after_ack", dbg_ack, 0);
    check("t6_after_rdy", cpu_rdy, 1);
    dbg_req = 1'b1; dbg_addr = 16'h0500; dbg_wr_enable = 1'b1; dbg_wr_data = 8'h77;
    cyc();
    check("t6w_issue_we", mem_wr_enable, 1);
    reset = 1'b1;
    cyc();
    check("t6w_committed", mem[16'h0500], 8'h77);
    check("t6w_ack", dbg_ack, 0);
    reset = 1'b0; dbg_req = 1'b0; dbg_wr_enable = 1'b0;
    cyc();
    check("t6w_rdy", cpu_rdy, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
